// File: rtl/encoder_pkg.sv
// Shared types and default constants for the spike-encoder sequencer and the encoder it feeds.
package encoder_pkg;

  localparam int DEF_IMAGE_SIZE      = 5;
  localparam int DEF_PIXEL_MAX_VALUE = 10;
  localparam int DEF_TIMEOUT_CYCLES  = 4096;
  localparam int DEF_PIXEL_BITS      = $clog2(DEF_PIXEL_MAX_VALUE);

  typedef logic [DEF_PIXEL_BITS:0] pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_FIRE     = 3'd2,
    ST_WAIT_ENC = 3'd3,
    ST_FINISH   = 3'd4
  } state_t;

endpackage

// File: rtl/encoder_sequencer_if.sv
// Bundle of control, pixel-stream, encoder and AER-tap signals around encoder_sequencer.
interface encoder_sequencer_if #(
  parameter int IMAGE_SIZE      = encoder_pkg::DEF_IMAGE_SIZE,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_BITS      = encoder_pkg::DEF_PIXEL_BITS
);
  import encoder_pkg::*;

  logic                       start;
  logic [7:0]                 num_images;
  logic                       abort;

  // Pixel stream: a beat transfers on every rising clk edge where pix_valid and
  // pix_ready are both high; the source holds pix_data stable while pix_valid is
  // high and waits, and pix_ready never depends on pix_valid.
  logic                       pix_valid;
  logic [PIXEL_BITS:0]        pix_data;
  logic                       pix_ready;

  logic [PIXEL_BITS:0]        image [0:IMAGE_SIZE-1];
  logic                       new_image;
  logic                       image_encoded;
  logic                       spk_req;
  logic                       spk_ack;

  logic                       busy;
  logic                       done;
  logic [7:0]                 img_count;
  logic [IMAGE_SIZE_BITS:0]   spike_cnt;
  logic                       err_timeout;
  state_t                     dbg_state;

  modport slave (
    input  start, num_images, abort, pix_valid, pix_data, image_encoded, spk_req, spk_ack,
    output pix_ready, image, new_image, busy, done, img_count, spike_cnt, err_timeout, dbg_state
  );

  modport master (
    output start, num_images, abort, pix_valid, pix_data, image_encoded, spk_req, spk_ack,
    input  pix_ready, image, new_image, busy, done, img_count, spike_cnt, err_timeout, dbg_state
  );

endinterface

// File: rtl/encoder_sequencer.sv
// Batch sequencer: loads images pixel by pixel, kicks the encoder, waits for its
// completion edge under a watchdog, and counts AER spikes seen on the output tap.
module encoder_sequencer
  import encoder_pkg::*;
#(
  parameter int IMAGE_SIZE      = DEF_IMAGE_SIZE,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE = DEF_PIXEL_MAX_VALUE,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE),
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  encoder_sequencer_if.slave bus
);

  localparam int WDOG_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDOG_W-1:0]          WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IMAGE_SIZE_BITS-1:0] LAST_IDX  = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);

  if (PIXEL_MAX_VALUE >= (1 << (PIXEL_BITS + 1))) begin : g_pixel_width_check
    $error("PIXEL_BITS is too narrow to hold PIXEL_MAX_VALUE");
  end

  state_t                     state;
  logic [IMAGE_SIZE_BITS-1:0] pix_idx;
  logic [PIXEL_BITS:0]        image_q [0:IMAGE_SIZE-1];
  logic [7:0]                 num_lat;
  logic [7:0]                 img_count;
  logic [7:0]                 count_inc;
  logic [IMAGE_SIZE_BITS:0]   spike_cnt;
  logic [WDOG_W-1:0]          wdog;
  logic                       new_image;
  logic                       busy;
  logic                       done;
  logic                       err_timeout;
  logic                       enc_q;
  logic                       ack_q;
  logic                       enc_rise;
  logic                       spk_edge;

  // Completion must be a fresh rising edge so a level left high by the previous
  // image cannot finish the current one.
  always_comb begin
    enc_rise  = bus.image_encoded & ~enc_q;
    spk_edge  = bus.spk_req & bus.spk_ack & ~ack_q;
    count_inc = img_count + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pix_idx     <= '0;
      num_lat     <= '0;
      img_count   <= '0;
      spike_cnt   <= '0;
      wdog        <= '0;
      new_image   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      enc_q       <= 1'b0;
      ack_q       <= 1'b0;
      for (int i = 0; i < IMAGE_SIZE; i++) image_q[i] <= '0;
    end else begin
      enc_q     <= bus.image_encoded;
      ack_q     <= bus.spk_ack;
      new_image <= 1'b0;
      done      <= 1'b0;
      if (bus.abort && state != ST_IDLE) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        pix_idx <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              if (bus.num_images != 8'd0) begin
                num_lat     <= bus.num_images;
                img_count   <= '0;
                err_timeout <= 1'b0;
                pix_idx     <= '0;
                busy        <= 1'b1;
                state       <= ST_LOAD;
              end else begin
                done <= 1'b1;
              end
            end
          end
          ST_LOAD: begin
            if (bus.pix_valid) begin
              image_q[pix_idx] <= bus.pix_data;
              if (pix_idx == LAST_IDX) begin
                pix_idx   <= '0;
                new_image <= 1'b1;
                state     <= ST_FIRE;
              end else begin
                pix_idx <= pix_idx + 1'b1;
              end
            end
          end
          ST_FIRE: begin
            spike_cnt <= '0;
            wdog      <= '0;
            state     <= ST_WAIT_ENC;
          end
          ST_WAIT_ENC: begin
            if (spk_edge && spike_cnt != '1) spike_cnt <= spike_cnt + 1'b1;
            // Completion wins over a watchdog expiry in the same cycle.
            if (enc_rise) begin
              img_count <= count_inc;
              if (count_inc == num_lat) begin
                done  <= 1'b1;
                state <= ST_FINISH;
              end else begin
                state <= ST_LOAD;
              end
            end else if (wdog == WDOG_LAST) begin
              err_timeout <= 1'b1;
              done        <= 1'b1;
              state       <= ST_FINISH;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          ST_FINISH: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.pix_ready   = (state == ST_LOAD);
  assign bus.image       = image_q;
  assign bus.new_image   = new_image;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.img_count   = img_count;
  assign bus.spike_cnt   = spike_cnt;
  assign bus.err_timeout = err_timeout;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_encoder_sequencer.sv
// Directed bench for encoder_sequencer: batch flow, stale completion level, watchdog,
// abort, spike counting, empty batch and mid-batch reset.
module tb_encoder_sequencer;
  import encoder_pkg::*;

  localparam int IMG_W     = 25;
  localparam int ENC_PULSE = 0;
  localparam int ENC_HOLD  = 1;
  localparam int ENC_NEVER = 2;
  localparam int ENC_DELAY = 50;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  int   enc_mode;
  int   ni_seen;
  int   done_seen;

  logic [IMG_W-1:0] exp_img_q [$];
  logic [8:0]       exp_done_q [$];

  encoder_sequencer_if #(.IMAGE_SIZE(5), .IMAGE_SIZE_BITS(3), .PIXEL_BITS(4)) bus ();

  encoder_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: event missing or unexpected", name);
  endtask

  function automatic logic [IMG_W-1:0] pack5(input int a, input int b, input int c,
                                             input int d, input int e);
    return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [IMG_W-1:0] dut_image();
    logic [IMG_W-1:0] v;
    v = '0;
    for (int i = 0; i < 5; i++) v[i*5 +: 5] = bus.image[i];
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [7:0] n);
    bus.start      = 1'b1;
    bus.num_images = n;
    @(posedge clk); #1;
    bus.start      = 1'b0;
  endtask

  task automatic send_beats(input logic [IMG_W-1:0] img, input int n);
    int waited;
    for (int i = 0; i < n; i++) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = img[i*5 +: 5];
      waited = 0;
      @(negedge clk);
      while (!bus.pix_ready && waited < 300) begin
        @(negedge clk);
        waited++;
      end
      if (!bus.pix_ready) fail_now("pix_ready_wait");
      @(posedge clk); #1;
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.done), 32'd1);
  endtask

  task automatic spk_step(input logic req, input logic ack);
    bus.spk_req = req;
    bus.spk_ack = ack;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- encoder model ----------------
  initial begin
    bus.image_encoded = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.new_image) begin
        if (enc_mode == ENC_NEVER) begin
          bus.image_encoded = 1'b0;
        end else if (enc_mode == ENC_PULSE) begin
          repeat (ENC_DELAY) @(posedge clk);
          #1 bus.image_encoded = 1'b1;
          repeat (3) @(posedge clk);
          #1 bus.image_encoded = 1'b0;
        end else if (bus.image_encoded) begin
          repeat (20) @(posedge clk);
          #1 bus.image_encoded = 1'b0;
          repeat (2) @(posedge clk);
          #1 bus.image_encoded = 1'b1;
        end else begin
          repeat (ENC_DELAY) @(posedge clk);
          #1 bus.image_encoded = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  initial begin
    logic [IMG_W-1:0] prev_img;
    logic [IMG_W-1:0] cur;
    logic             prev_beat;
    logic             prev_ni;
    logic             prev_done;
    prev_img  = '0;
    prev_beat = 1'b0;
    prev_ni   = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_img  = '0;
        prev_beat = 1'b0;
        prev_ni   = 1'b0;
        prev_done = 1'b0;
      end else begin
        cur = dut_image();
        if (!prev_beat) check("image_stable", 32'(cur), 32'(prev_img));
        if (bus.new_image) begin
          ni_seen++;
          check("new_image_single_cycle", 32'(prev_ni), 32'd0);
          if (exp_img_q.size() == 0) fail_now("unexpected_new_image");
          else check("image_at_new_image", 32'(cur), 32'(exp_img_q.pop_front()));
        end
        if (bus.done) begin
          done_seen++;
          check("done_single_cycle", 32'(prev_done), 32'd0);
          if (exp_done_q.size() == 0) fail_now("unexpected_done");
          else check("done_err_and_count", 32'({bus.err_timeout, bus.img_count}),
                     32'(exp_done_q.pop_front()));
        end
        if (bus.pix_ready) check("pix_ready_implies_busy", 32'(bus.busy), 32'd1);
        prev_beat = bus.pix_ready & bus.pix_valid;
        prev_img  = cur;
        prev_ni   = bus.new_image;
        prev_done = bus.done;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int ni0;
    int dn0;
    int wait_cnt;
    int n;
    tests_run      = 0;
    tests_failed   = 0;
    ni_seen        = 0;
    done_seen      = 0;
    enc_mode       = ENC_PULSE;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.num_images = 8'd0;
    bus.abort      = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.pix_data   = '0;
    bus.spk_req    = 1'b0;
    bus.spk_ack    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
    check("rst_outputs", 32'({bus.new_image, bus.done, bus.err_timeout, bus.img_count, bus.spike_cnt}), 32'd0);
    check("rst_image", 32'(dut_image()), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // Two-image batch, with a START during the batch that must be ignored
    ni0 = ni_seen; dn0 = done_seen;
    enc_mode = ENC_PULSE;
    exp_img_q.push_back(pack5(3, 0, 10, 7, 1));
    exp_img_q.push_back(pack5(5, 5, 2, 9, 4));
    exp_done_q.push_back({1'b0, 8'd2});
    pulse_start(8'd2);
    send_beats(pack5(3, 0, 10, 7, 1), 5);
    pulse_start(8'd7);
    send_beats(pack5(5, 5, 2, 9, 4), 5);
    wait_done("batch2_done", 400);
    check("batch2_img_count", 32'(bus.img_count), 32'd2);
    check("batch2_image_literal", 32'(dut_image()), 32'h04488A5);
    repeat (5) @(negedge clk);
    check("batch2_new_image_pulses", 32'(ni_seen - ni0), 32'd2);
    check("batch2_done_pulses", 32'(done_seen - dn0), 32'd1);
    check("batch2_idle_busy", 32'(bus.busy), 32'd0);

    // Completion level still high from the first image when the second fires
    enc_mode = ENC_HOLD;
    exp_img_q.push_back(pack5(1, 1, 1, 1, 1));
    exp_img_q.push_back(pack5(2, 4, 6, 8, 10));
    exp_done_q.push_back({1'b0, 8'd2});
    pulse_start(8'd2);
    send_beats(pack5(1, 1, 1, 1, 1), 5);
    send_beats(pack5(2, 4, 6, 8, 10), 5);
    repeat (10) @(negedge clk);
    check("stale_level_still_waiting", 32'(bus.dbg_state), 32'(ST_WAIT_ENC));
    check("stale_level_count", 32'(bus.img_count), 32'd1);
    wait_done("stale_level_done", 200);
    check("stale_level_final_count", 32'(bus.img_count), 32'd2);
    repeat (3) @(negedge clk);

    // Watchdog expiry with an encoder that never completes
    enc_mode = ENC_NEVER;
    exp_img_q.push_back(pack5(7, 0, 0, 0, 7));
    exp_done_q.push_back({1'b1, 8'd0});
    pulse_start(8'd1);
    send_beats(pack5(7, 0, 0, 0, 7), 5);
    wait_cnt = 0;
    n = 0;
    while (!bus.done && n < 400) begin
      @(negedge clk);
      if (bus.dbg_state == ST_WAIT_ENC) wait_cnt++;
      n++;
    end
    check("timeout_done", 32'(bus.done), 32'd1);
    check("timeout_wait_cycles", 32'(wait_cnt), 32'd64);
    check("timeout_err", 32'(bus.err_timeout), 32'd1);
    check("timeout_img_count", 32'(bus.img_count), 32'd0);
    repeat (3) @(negedge clk);

    // Abort after the third pixel beat, then a fresh batch from pixel 0
    enc_mode = ENC_PULSE;
    ni0 = ni_seen; dn0 = done_seen;
    pulse_start(8'd1);
    send_beats(pack5(9, 9, 9, 9, 9), 3);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_pix_ready", 32'(bus.pix_ready), 32'd0);
    repeat (10) @(negedge clk);
    check("abort_no_new_image", 32'(ni_seen - ni0), 32'd0);
    check("abort_no_done", 32'(done_seen - dn0), 32'd0);
    exp_img_q.push_back(pack5(1, 2, 3, 4, 5));
    exp_done_q.push_back({1'b0, 8'd1});
    pulse_start(8'd1);
    send_beats(pack5(1, 2, 3, 4, 5), 5);
    wait_done("restart_done", 200);
    check("restart_image_literal", 32'(dut_image()), 32'h0520C41);
    repeat (3) @(negedge clk);

    // Spike counting on the AER tap
    enc_mode = ENC_NEVER;
    exp_img_q.push_back(pack5(0, 10, 0, 10, 0));
    exp_done_q.push_back({1'b1, 8'd0});
    pulse_start(8'd1);
    send_beats(pack5(0, 10, 0, 10, 0), 5);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      spk_step(1'b1, 1'b0);
      spk_step(1'b1, 1'b1);
      spk_step(1'b0, 1'b1);
      spk_step(1'b0, 1'b0);
    end
    spk_step(1'b0, 1'b1);
    spk_step(1'b0, 1'b0);
    @(negedge clk);
    check("spike_count", 32'(bus.spike_cnt), 32'd5);
    wait_done("spike_batch_done", 200);
    repeat (3) @(negedge clk);

    // Empty batch: DONE one cycle after START, never busy
    exp_done_q.push_back({1'b1, 8'd0});
    pulse_start(8'd0);
    @(negedge clk);
    check("empty_done", 32'(bus.done), 32'd1);
    check("empty_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("empty_done_drop", 32'(bus.done), 32'd0);
    check("empty_busy_after", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of LOAD
    enc_mode = ENC_PULSE;
    pulse_start(8'd1);
    send_beats(pack5(6, 6, 6, 6, 6), 2);
    #3 rst = 1'b1;
    #1;
    check("midrst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("midrst_busy_ready", 32'({bus.busy, bus.pix_ready}), 32'd0);
    check("midrst_outputs", 32'({bus.new_image, bus.done, bus.err_timeout, bus.img_count, bus.spike_cnt}), 32'd0);
    check("midrst_image", 32'(dut_image()), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    check("exp_img_q_drained", 32'(exp_img_q.size()), 32'd0);
    check("exp_done_q_drained", 32'(exp_done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/encoder_sequencer.md
ENCODER_SEQUENCER -- requirements
Module: encoder_sequencer

Interface
- REQ-001: Parameter IMAGE_SIZE, default 5, pixels per image.
- REQ-002: Parameter IMAGE_SIZE_BITS, default $clog2(IMAGE_SIZE), pixel index width.
- REQ-003: Parameter PIXEL_MAX_VALUE, default 10, maximum pixel value.
- REQ-004: Parameter PIXEL_BITS, default $clog2(PIXEL_MAX_VALUE), pixel value width is PIXEL_BITS+1.
- REQ-005: Parameter TIMEOUT_CYCLES, default 4096, encode watchdog limit in cycles.
- REQ-006: The block has one clock; reset is asynchronous and active-high.
- REQ-007: CLK, input, 1, system clock.
- REQ-008: RST, input, 1, asynchronous active-high reset.
- REQ-009: START, input, 1, one-cycle pulse that begins a batch.
- REQ-010: NUM_IMAGES, input, 8, batch length, sampled on START.
- REQ-011: ABORT, input, 1, synchronous batch cancel.
- REQ-012: PIX_VALID, input, 1, pixel stream valid.
- REQ-013: PIX_DATA, input, PIXEL_BITS+1, pixel value.
- REQ-014: PIX_READY, output, 1, pixel stream ready.
- REQ-015: IMAGE, output, array [0:IMAGE_SIZE-1] of PIXEL_BITS+1, image to the encoder.
- REQ-016: NEW_IMAGE, output, 1, encoder start pulse.
- REQ-017: IMAGE_ENCODED, input, 1, encoder completion level.
- REQ-018: SPK_REQ and SPK_ACK, inputs, 1 each, a passive tap on the encoder AER output handshake.
- REQ-019: BUSY, output, 1, high when the FSM is not in IDLE.
- REQ-020: DONE, output, 1, one-cycle pulse at the end of a batch.
- REQ-021: IMG_COUNT, output, 8, number of images encoded in the current batch.
- REQ-022: SPIKE_CNT, output, IMAGE_SIZE_BITS+1, spikes seen for the current image.
- REQ-023: ERR_TIMEOUT, output, 1, sticky watchdog error.

Function
- REQ-024: The FSM has states IDLE, LOAD, FIRE, WAIT_ENC and FINISH.
- REQ-025: IDLE transitions:
  - START with NUM_IMAGES≠0 → LOAD, clearing IMG_COUNT and ERR_TIMEOUT.
  - START with NUM_IMAGES=0 → DONE pulses on the next cycle and the FSM stays in IDLE.
- REQ-026: LOAD behaviour:
  - PIX_READY=1 in LOAD only.
  - Each PIX_VALID&PIX_READY beat writes IMAGE[pix_idx] and increments pix_idx.
  - The beat with pix_idx=IMAGE_SIZE-1 moves the FSM to FIRE and resets pix_idx to 0.
- REQ-027: IMAGE is written only in LOAD and stays stable through FIRE and WAIT_ENC.
- REQ-028: In FIRE, NEW_IMAGE=1 for exactly one cycle, SPIKE_CNT and the watchdog clear, and the FSM moves to WAIT_ENC.
- REQ-029: Completion is a 0→1 edge of IMAGE_ENCODED detected in WAIT_ENC against a registered prior value; a level held high from an earlier image does not count.
- REQ-030: On completion, IMG_COUNT increments; the FSM goes to FINISH if the new count equals the latched NUM_IMAGES, else to LOAD.
- REQ-031: The watchdog counts cycles in WAIT_ENC; on reaching TIMEOUT_CYCLES-1 without completion it sets ERR_TIMEOUT and moves to FINISH.
- REQ-032: SPIKE_CNT increments on each SPK_ACK 0→1 edge while SPK_REQ=1 during WAIT_ENC, saturating at its maximum; SPK_REQ and SPK_ACK are never driven.
- REQ-033: FINISH pulses DONE for one cycle, then the FSM returns to IDLE.
- REQ-034: ABORT in any non-IDLE state returns the FSM to IDLE on the next edge, with NEW_IMAGE=0, PIX_READY=0 and no DONE pulse; ABORT has priority over all other transitions.
- REQ-035: START is ignored while BUSY=1.
- REQ-036: Completion and timeout in the same cycle counts as completion.
- REQ-037: All outputs are registered except PIX_READY, which is decoded from the state.

Reset
- REQ-038: RST forces state IDLE, IMAGE all 0, pix_idx 0, NEW_IMAGE 0, PIX_READY 0, BUSY 0, DONE 0, IMG_COUNT 0, SPIKE_CNT 0, ERR_TIMEOUT 0, and clears the edge-detect registers.
- REQ-039: RST asserted mid-batch takes effect immediately, without waiting for the encoder.

Structure
- REQ-040: Package encoder_pkg holds:
  - the FSM state enum;
  - the default IMAGE_SIZE, PIXEL_MAX_VALUE and TIMEOUT_CYCLES constants;
  - the pixel-type typedef shared with encoder.
- REQ-041: The block is a single module with no sub-modules; the watchdog is an inline counter.

Verification
- REQ-042: START with NUM_IMAGES=2, pixels {3,0,10,7,1} then {5,5,2,9,4}, encoder model asserting IMAGE_ENCODED 50 cycles after NEW_IMAGE:
  - two single-cycle NEW_IMAGE pulses;
  - IMAGE matches each pixel set at its pulse;
  - IMG_COUNT=2 and DONE pulses once.
- REQ-043: IMAGE_ENCODED held high from the previous image when the second NEW_IMAGE fires → no premature completion; the next rising edge advances the FSM.
- REQ-044: TIMEOUT_CYCLES=64 with an encoder that never completes → ERR_TIMEOUT=1 after 64 cycles in WAIT_ENC, DONE pulses, IMG_COUNT=0.
- REQ-045: ABORT after the 3rd pixel beat of image 1 → BUSY=0 next cycle, no NEW_IMAGE, no DONE; a new START then loads from pixel 0.
- REQ-046: Five 4-phase SPK_REQ/SPK_ACK handshakes during WAIT_ENC → SPIKE_CNT=5; SPK_ACK toggled with SPK_REQ=0 → no count.
- REQ-047: START with NUM_IMAGES=0 → DONE pulses one cycle later, BUSY stays 0; RST mid-LOAD → all outputs return to their reset values.
